muldiv_seq: RTL and testbench

Iterative RV32M multiply/divide sequencer in the EX stage, beside the single-cycle ALU. It accepts one operation from the pipeline and holds the pipeline stalled through `busy`. It runs a radix-2 shift-add or shift-subtract loop over 32 cycles, applies sign correction, and returns a 32-bit result with a one-cycle `done` pulse. It also handles flush, divide-by-zero and signed overflow per the RISC-V M spec.

---
 rtl/muldiv_pkg.sv | 47 ++++
 rtl/muldiv_sign_fix.sv | 82 ++++++++
 rtl/muldiv_seq.sv | 183 ++++++++++++++++++
 tb/tb_muldiv_seq.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide sequencer.
// Holds the funct3 encodings, FSM state type, width constant, the special
// result constants, and the early-out result helper used when
// MULDIV_EARLY_OUT_EN is defined.
package muldiv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    localparam logic [XLEN-1:0] DIV0_Q  = 32'hFFFF_FFFF;
    localparam logic [XLEN-1:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Result of an operation that can be resolved without iterating:
    // divide-by-zero, signed overflow, or a multiply with a zero operand.
    function automatic logic [XLEN-1:0] special_result(
        input logic [2:0]      f3,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b
    );
        logic [XLEN-1:0] r;
        r = '0;
        if (f3[2]) begin
            if (b == '0) begin
                r = f3[1] ? a : DIV0_Q;
            end else begin
                r = f3[1] ? '0 : INT_MIN;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Combinational sign handling for the multiply/divide sequencer.
// Operand side: per-op magnitudes, result sign and special-case flags,
// consumed by the IDLE latch. Result side: two's-complement correction
// and final selection of product half / quotient / remainder in FIX.
module muldiv_sign_fix
    import muldiv_pkg::*;
(
    input  logic [2:0]        op_funct3,
    input  logic [XLEN-1:0]   op_a,
    input  logic [XLEN-1:0]   op_b,
    output logic [XLEN-1:0]   a_mag,
    output logic [XLEN-1:0]   b_mag,
    output logic              res_neg,
    output logic              div0,
    output logic              ovf,
    input  logic [2:0]        fix_funct3,
    input  logic              fix_neg,
    input  logic              fix_div0,
    input  logic              fix_ovf,
    input  logic [2*XLEN-1:0] prod,
    input  logic [XLEN-1:0]   quot,
    input  logic [XLEN-1:0]   rem,
    output logic [XLEN-1:0]   fix_result
);

    logic a_signed;
    logic b_signed;
    logic a_neg;
    logic b_neg;

    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quot_s;
    logic [XLEN-1:0]   rem_s;

    // Operand magnitudes, result sign and special-case detection.
    always_comb begin
        a_signed = (op_funct3 == F3_MULH) || (op_funct3 == F3_MULHSU) ||
                   (op_funct3 == F3_DIV)  || (op_funct3 == F3_REM);
        b_signed = (op_funct3 == F3_MULH) || (op_funct3 == F3_DIV) ||
                   (op_funct3 == F3_REM);
        a_neg    = a_signed && op_a[XLEN-1];
        b_neg    = b_signed && op_b[XLEN-1];
        a_mag    = a_neg ? (~op_a + 1'b1) : op_a;
        b_mag    = b_neg ? (~op_b + 1'b1) : op_b;
        // Remainder follows the dividend; everything else follows the XOR.
        if (op_funct3 == F3_REM) begin
            res_neg = a_neg;
        end else begin
            res_neg = a_neg ^ b_neg;
        end
        div0 = op_funct3[2] && (op_b == '0);
        ovf  = ((op_funct3 == F3_DIV) || (op_funct3 == F3_REM)) &&
               (op_a == INT_MIN) && (op_b == '1);
    end

    // Sign correction and result selection.
    always_comb begin
        prod_s     = fix_neg ? (~prod + 1'b1) : prod;
        quot_s     = fix_neg ? (~quot + 1'b1) : quot;
        rem_s      = fix_neg ? (~rem + 1'b1)  : rem;
        fix_result = '0;
        case (fix_funct3)
            F3_MUL:                       fix_result = prod_s[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fix_result = prod_s[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU: begin
                if (fix_div0) begin
                    fix_result = DIV0_Q;
                end else if (fix_ovf) begin
                    fix_result = INT_MIN;
                end else begin
                    fix_result = quot_s;
                end
            end
            default: begin
                // A zero divisor leaves the dividend magnitude in the
                // remainder, so sign correction restores A unchanged.
                fix_result = fix_ovf ? '0 : rem_s;
            end
        endcase
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer (radix-2, 32 iterations).
// IDLE -> CALC (32 cycles) -> FIX -> DONE, stalling the pipeline via busy.
// Optional feature macro: MULDIV_EARLY_OUT_EN -- divide-by-zero, signed
// overflow and zero-operand multiplies skip straight to DONE.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ITER_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic            kill,
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    state_t state;
    state_t state_nx;

    logic [ITER_W-1:0] counter;
    logic [2:0]        f3_q;
    logic              neg_q;
    logic              div0_q;
    logic              ovf_q;
    logic [XLEN-1:0]   opnd_q;
    logic [XLEN-1:0]   acc_hi;
    logic [XLEN-1:0]   acc_lo;
    logic [XLEN-1:0]   result_q;

    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            res_neg;
    logic            div0;
    logic            ovf;
    logic [XLEN-1:0] fix_result;

    logic            accept;
    logic            take_early;
    logic            last_iter;

    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN-1:0] div_diff;
    logic            div_ok;
    logic [XLEN-1:0] hi_nx;
    logic [XLEN-1:0] lo_nx;

    muldiv_sign_fix u_sign_fix (
        .op_funct3  (funct3),
        .op_a       (A),
        .op_b       (B),
        .a_mag      (a_mag),
        .b_mag      (b_mag),
        .res_neg    (res_neg),
        .div0       (div0),
        .ovf        (ovf),
        .fix_funct3 (f3_q),
        .fix_neg    (neg_q),
        .fix_div0   (div0_q),
        .fix_ovf    (ovf_q),
        .prod       ({acc_hi, acc_lo}),
        .quot       (acc_lo),
        .rem        (acc_hi),
        .fix_result (fix_result)
    );

    assign accept    = (state == IDLE) && start && !kill;
    assign last_iter = (counter == ITER_W'(XLEN - 1));

`ifdef MULDIV_EARLY_OUT_EN
    logic mul_zero;
    assign mul_zero   = !funct3[2] && ((A == '0) || (B == '0));
    assign take_early = div0 || ovf || mul_zero;
`else
    assign take_early = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        state_nx = state;
        ready    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (accept) begin
                    state_nx = take_early ? DONE : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (last_iter) begin
                    state_nx = FIX;
                end
            end
            FIX: begin
                busy     = 1'b1;
                state_nx = DONE;
            end
            default: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
        endcase
        if (kill) begin
            state_nx = IDLE;
        end
    end

    // One radix-2 step: shift-add for multiply, restoring subtract for divide.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd_q : '0)};
        div_shift = {acc_hi, acc_lo[XLEN-1]};
        div_ok    = (div_shift >= {1'b0, opnd_q});
        // The true difference is below the divisor, so 32 bits suffice.
        div_diff  = div_shift[XLEN-1:0] - opnd_q;
        if (f3_q[2]) begin
            hi_nx = div_ok ? div_diff : div_shift[XLEN-1:0];
            lo_nx = {acc_lo[XLEN-2:0], div_ok};
        end else begin
            hi_nx = mul_sum[XLEN:1];
            lo_nx = {mul_sum[0], acc_lo[XLEN-1:1]};
        end
    end

    // Operation latch, iteration counter and accumulators.
    always_ff @(posedge clk) begin
        if (rst) begin
            counter <= '0;
            f3_q    <= '0;
            neg_q   <= 1'b0;
            div0_q  <= 1'b0;
            ovf_q   <= 1'b0;
            opnd_q  <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
        end else if (accept) begin
            counter <= '0;
            f3_q    <= funct3;
            neg_q   <= res_neg;
            div0_q  <= div0;
            ovf_q   <= ovf;
            opnd_q  <= funct3[2] ? b_mag : a_mag;
            acc_hi  <= '0;
            acc_lo  <= funct3[2] ? a_mag : b_mag;
        end else if ((state == CALC) && !kill) begin
            counter <= counter + ITER_W'(1);
            acc_hi  <= hi_nx;
            acc_lo  <= lo_nx;
        end
    end

    // Result register: written in FIX, or at acceptance on the early path.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
        end else if (accept && take_early) begin
            result_q <= special_result(funct3, A, B);
        end else if ((state == FIX) && !kill) begin
            result_q <= fix_result;
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed vector table, randomized
// ops against an arithmetic reference model, plus kill / held-start /
// mid-op reset sequences.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] A;
    logic [31:0] B;
    logic        kill;
    logic        ready;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    muldiv_seq #(.XLEN(32), .ITER_W(6)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .A      (A),
        .B      (B),
        .kill   (kill),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // RISC-V M semantics computed with plain 64-bit arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint unsigned pu;
        longint          ps;
        int              sa;
        int              sb;
        int              q;
        sa = a;
        sb = b;
        case (f3)
            3'd0: begin pu = {32'b0, a} * {32'b0, b}; return pu[31:0]; end
            3'd1: begin ps = longint'($signed(a)) * longint'($signed(b)); return ps[63:32]; end
            3'd2: begin ps = longint'($signed(a)) * longint'({32'b0, b}); return ps[63:32]; end
            3'd3: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                q = sa / sb;
                return q;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                q = sa % sb;
                return q;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Edges from the accepting edge (inclusive) until done is visible.
    function automatic int exp_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        if (f3 >= 3'd4 && b == 0) return 1;
        if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        if (f3 < 3'd4 && (a == 0 || b == 0)) return 1;
`endif
        return 34;
    endfunction

    task automatic wait_ready();
        int guard;
        guard = 0;
        while (!ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check("wait_ready", {31'b0, ready}, 32'd1);
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output logic busy_ok);
        busy_ok = 1'b1;
        wait_ready();
        @(negedge clk);
        start  = 1'b1;
        funct3 = f3;
        A      = a;
        B      = b;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 100) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (busy) busy_ok = 1'b0;
        res = result;
    endtask

    task automatic do_checked(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] exp);
        logic [31:0] res;
        int          lat;
        logic        bok;
        run_op(f3, a, b, res, lat, bok);
        check({tag, "_result"}, res, exp);
        check({tag, "_latency"}, lat, exp_latency(f3, a, b));
        check({tag, "_busy"}, {31'b0, bok}, 32'd1);
        @(posedge clk); #1;
        check({tag, "_after"}, {29'b0, ready, busy, done}, 32'b100);
        check({tag, "_held"}, result, exp);
    endtask

    vec_t vecs[$];

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] prev;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [2:0]  rf;
        int          dones;
        int          first_done;
        int          last_done;
        int          spacing_bad;

        rst = 1'b1; start = 1'b0; kill = 1'b0; funct3 = '0; A = '0; B = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_status", {29'b0, ready, busy, done}, 32'b100);
        check("reset_result", result, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        vecs.push_back('{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB});
        vecs.push_back('{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE});
        vecs.push_back('{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000});
        vecs.push_back('{3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF});
        vecs.push_back('{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD});
        vecs.push_back('{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF});
        vecs.push_back('{3'd5, 32'd100,        32'd7,         32'd14});
        vecs.push_back('{3'd7, 32'd100,        32'd7,         32'd2});
        vecs.push_back('{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF});
        vecs.push_back('{3'd7, 32'd5,          32'd0,         32'd5});
        vecs.push_back('{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000});
        vecs.push_back('{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0});
        vecs.push_back('{3'd4, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFFF});
        vecs.push_back('{3'd6, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9});
        vecs.push_back('{3'd0, 32'd0,          32'd12345,     32'd0});
        vecs.push_back('{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000});
        vecs.push_back('{3'd2, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000});

        foreach (vecs[i]) begin
            do_checked($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp);
        end

        for (int i = 0; i < 150; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'h0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: ra = 32'h0;
                3: begin ra = $urandom_range(0, 300); rb = $urandom_range(1, 20); end
                4: rb = $urandom_range(1, 5);
                default: ;
            endcase
            do_checked($sformatf("rnd%0d_f%0d", i, rf), rf, ra, rb, ref_model(rf, ra, rb));
        end

        // kill at counter=10: no done, result untouched, idle next cycle.
        wait_ready();
        prev = result;
        @(negedge clk);
        start = 1'b1; funct3 = 3'd4; A = 32'd1000; B = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        dones = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk); #1;
        check("kill_status", {29'b0, ready, busy, done}, 32'b100);
        check("kill_result", result, prev);
        @(negedge clk);
        kill = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("kill_no_done", dones, 0);
        do_checked("post_kill_mul", 3'd0, 32'd3, 32'd4, 32'd12);

        // start held high: one op per 35 cycles.
        wait_ready();
        @(negedge clk);
        start = 1'b1; funct3 = 3'd0; A = 32'd5; B = 32'd6;
        dones = 0; first_done = -1; last_done = -1; spacing_bad = 0;
        for (int e = 1; e <= 110; e++) begin
            @(posedge clk); #1;
            if (done) begin
                dones++;
                if (first_done < 0) first_done = e;
                else if (e - last_done != 35) spacing_bad++;
                last_done = e;
                check("held_result", result, 32'd30);
            end
        end
        @(negedge clk);
        start = 1'b0;
        check("held_count", dones, 3);
        check("held_first", first_done, 34);
        check("held_spacing", spacing_bad, 0);

        // rst at counter=5 returns everything to reset values.
        wait_ready();
        @(negedge clk);
        start = 1'b1; funct3 = 3'd5; A = 32'd999; B = 32'd10;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_status", {29'b0, ready, busy, done}, 32'b100);
        check("rst_result", result, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        do_checked("post_rst_divu", 3'd5, 32'd999, 32'd10, 32'd99);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
